pattern_gen_multichannel: RTL

Parametrised successor to the two-counter test pattern generator used to exercise the trigger/acquire path without an ADC.
- Produces CHANNELS independent synthetic waveforms at a programmable sample rate.
- Each channel is a phase accumulator with a selectable output shape: ramp, square, triangle or constant.
- All channels present one packed sample word per sample tick, using a valid/ready handshake with sticky overflow reporting.
- Sits in place of the ADC front end, feeding trigger_acquire.

---
 rtl/pattern_gen_multichannel.sv | 114 +++++++++++
 1 files changed

// File: rtl/pattern_gen_multichannel.sv
// Multichannel synthetic waveform source standing in for the ADC front end.
// Each channel is a phase accumulator shaped to ramp, square, triangle or constant.
module pattern_gen_multichannel #(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [DIV_WIDTH-1:0]             sample_div,
    input  logic [2*CHANNELS-1:0]            mode,
    input  logic [SAMPLE_WIDTH*CHANNELS-1:0] step,
    input  logic                             data_ready,
    input  logic                             clear_overflow,
    output logic [SAMPLE_WIDTH*CHANNELS-1:0] data_out,
    output logic                             data_valid,
    output logic                             overflow,
    output logic [15:0]                      drop_count
);

    localparam int W = SAMPLE_WIDTH;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0]    div_cnt;
    logic [W-1:0]            acc [CHANNELS];
    logic [W*CHANNELS-1:0]   shaped;
    logic                    tick;
    logic                    slot_free;
    logic                    drop;

    function automatic logic [W-1:0] shape(input logic [1:0] m,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] s);
        logic [W-1:0] t;
        t = {a[W-2:0], 1'b0};
        case (m)
            2'd0:    shape = a;
            2'd1:    shape = a[W-1] ? {W{1'b1}} : {W{1'b0}};
            2'd2:    shape = a[W-1] ? ~t : t;
            2'd3:    shape = s;
            default: shape = a;
        endcase
    endfunction

    // >= rather than == so lowering sample_div mid-count ticks immediately
    assign tick      = enable && (div_cnt >= sample_div);
    assign slot_free = !data_valid || data_ready;
    assign drop      = tick && !slot_free;

    // Shape every channel from its current accumulator phase
    always_comb begin
        shaped = {(W*CHANNELS){1'b0}};
        for (int n = 0; n < CHANNELS; n++) begin
            shaped[n*W +: W] = shape(mode[2*n +: 2], acc[n], step[n*W +: W]);
        end
    end

    // Sample-rate divider, parked at zero while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= {DIV_WIDTH{1'b0}};
        end else if (!enable || tick) begin
            div_cnt <= {DIV_WIDTH{1'b0}};
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Accumulators advance on every tick, even when the sample is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < CHANNELS; n++) begin
                acc[n] <= {W{1'b0}};
            end
        end else if (tick) begin
            for (int n = 0; n < CHANNELS; n++) begin
                acc[n] <= acc[n] + step[n*W +: W];
            end
        end
    end

    // Output register and valid/ready handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= {(W*CHANNELS){1'b0}};
            data_valid <= 1'b0;
        end else if (tick && slot_free) begin
            data_out   <= shaped;
            data_valid <= 1'b1;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end
    end

endmodule
